// File: rtl/core_mmu_section_xlat.sv
// MMU channel that translates one requester's word addresses through a fully-associative
// section TLB. It walks a one-level table on a miss and applies DAC/AP checks. fault_type: 0=translation, 1=domain, 2=permission.
module core_mmu_section_xlat #(
  parameter int TLB_ENTRIES = 4,
  parameter int VA_W        = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmu_enable,
  input  logic [VA_W-13:0] mmu_ttbr,
  input  logic [31:0]      mmu_dac,
  input  logic             privileged,
  input  logic             tlb_flush,
  input  logic             req_start,
  input  logic [VA_W-1:0]  req_addr,
  input  logic             req_write,
  input  logic             req_user,
  input  logic [31:0]      req_data_wr,
  input  logic [3:0]       req_data_be,
  output logic             req_ready,
  output logic             req_fault,
  output logic [31:0]      req_data_rd,
  output logic             bus_start,
  output logic [VA_W-1:0]  bus_addr,
  output logic             bus_write,
  output logic [31:0]      bus_data_wr,
  output logic [3:0]       bus_data_be,
  input  logic             bus_ready,
  input  logic [31:0]      bus_data_rd,
  output logic [VA_W-1:0]  fault_addr,
  output logic [1:0]       fault_type,
  output logic [3:0]       fault_domain
);
  // state  | meaning
  // IDLE   | waiting for req_start
  // LOOKUP | compare section index against TLB, check DAC/AP on hit
  // WALK   | descriptor read outstanding
  // FILL   | write descriptor into victim entry
  // ACCESS | data access outstanding
  // FAULT  | fault reported, req_ready/req_fault high
  localparam int OFF_W = VA_W - 12;
  localparam int PTR_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [1:0] FT_TRANS = 2'd0, FT_DOMAIN = 2'd1, FT_PERM = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WALK, S_FILL, S_ACCESS, S_FAULT} state_t;
  state_t r_state, w_state_nxt;

  logic [VA_W-1:0] r_va;
  logic            r_write, r_user;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [11:0]     r_desc_base;
  logic [3:0]      r_desc_dom;
  logic [1:0]      r_desc_ap;

  logic [TLB_ENTRIES-1:0] r_valid;
  logic [11:0]            r_tag  [TLB_ENTRIES];
  logic [11:0]            r_base [TLB_ENTRIES];
  logic [3:0]             r_dom  [TLB_ENTRIES];
  logic [1:0]             r_ap   [TLB_ENTRIES];
  logic [PTR_W-1:0]       r_rr;

  logic            r_req_ready, r_req_fault, r_bus_start, r_bus_write;
  logic [31:0]     r_req_data_rd, r_bus_data_wr;
  logic [VA_W-1:0] r_bus_addr, r_fault_addr;
  logic [3:0]      r_bus_be, r_fault_domain;
  logic [1:0]      r_fault_type;

  logic [11:0]      w_idx, w_hit_base;
  logic             w_hit, w_all_valid, w_eff_user, w_dom_fault, w_perm_fault, w_deny;
  logic [3:0]       w_hit_dom;
  logic [1:0]       w_hit_ap, w_dac_d;
  logic [PTR_W-1:0] w_victim;
  logic             w_walk_go, w_acc_go, w_fault_go, w_done;
  logic [VA_W-1:0]  w_acc_addr;
  logic             w_acc_write;
  logic [31:0]      w_acc_wd;
  logic [3:0]       w_acc_be;
  logic [1:0]       w_ftype;
  logic [3:0]       w_fdom;

  assign w_idx = r_va[VA_W-1:OFF_W];

  always_comb begin
    w_hit      = 1'b0;
    w_hit_base = '0;
    w_hit_dom  = '0;
    w_hit_ap   = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (!w_hit && r_valid[i] && r_tag[i] == w_idx) begin
        w_hit      = 1'b1;
        w_hit_base = r_base[i];
        w_hit_dom  = r_dom[i];
        w_hit_ap   = r_ap[i];
      end
    end
  end

  // Lowest invalid entry first; round-robin only once the TLB is full.
  always_comb begin
    w_all_valid = &r_valid;
    w_victim    = r_rr;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_victim = PTR_W'(i);
    end
  end

  always_comb begin
    w_dac_d      = mmu_dac[{w_hit_dom, 1'b0} +: 2];
    w_eff_user   = r_user | ~privileged;
    w_dom_fault  = (w_dac_d == 2'b00) || (w_dac_d == 2'b10);
    w_perm_fault = 1'b0;
    if (w_dac_d == 2'b01) begin
      case (w_hit_ap)
        2'b00:   w_perm_fault = 1'b1;
        2'b01:   w_perm_fault = w_eff_user;
        2'b10:   w_perm_fault = w_eff_user & r_write;
        default: w_perm_fault = 1'b0;
      endcase
    end
    w_deny = w_dom_fault | w_perm_fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_start) w_state_nxt = mmu_enable ? S_LOOKUP : S_ACCESS;
      S_LOOKUP: w_state_nxt = !w_hit ? S_WALK : (w_deny ? S_FAULT : S_ACCESS);
      S_WALK:   if (bus_ready) w_state_nxt = (bus_data_rd[1:0] == 2'b10) ? S_FILL : S_FAULT;
      S_FILL:   w_state_nxt = S_LOOKUP;
      S_ACCESS: if (bus_ready) w_state_nxt = S_IDLE;
      S_FAULT:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_walk_go   = 1'b0;
    w_acc_go    = 1'b0;
    w_fault_go  = 1'b0;
    w_done      = 1'b0;
    w_acc_addr  = '0;
    w_acc_write = 1'b0;
    w_acc_wd    = '0;
    w_acc_be    = '0;
    w_ftype     = FT_TRANS;
    w_fdom      = '0;
    case (r_state)
      S_IDLE: begin
        if (req_start && !mmu_enable) begin
          w_acc_go    = 1'b1;
          w_acc_addr  = req_addr;
          w_acc_write = req_write;
          w_acc_wd    = req_data_wr;
          w_acc_be    = req_data_be;
        end
      end
      S_LOOKUP: begin
        if (!w_hit) begin
          w_walk_go = 1'b1;
        end else if (w_deny) begin
          w_fault_go = 1'b1;
          w_ftype    = w_dom_fault ? FT_DOMAIN : FT_PERM;
          w_fdom     = w_hit_dom;
        end else begin
          w_acc_go    = 1'b1;
          w_acc_addr  = {w_hit_base, r_va[OFF_W-1:0]};
          w_acc_write = r_write;
          w_acc_wd    = r_wdata;
          w_acc_be    = r_be;
        end
      end
      S_WALK:   w_fault_go = bus_ready && (bus_data_rd[1:0] != 2'b10);
      S_ACCESS: w_done     = bus_ready;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_va        <= '0;
      r_write     <= 1'b0;
      r_user      <= 1'b0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_desc_base <= '0;
      r_desc_dom  <= '0;
      r_desc_ap   <= '0;
    end else begin
      if (r_state == S_IDLE && req_start) begin
        r_va    <= req_addr;
        r_write <= req_write;
        r_user  <= req_user;
        r_wdata <= req_data_wr;
        r_be    <= req_data_be;
      end
      if (r_state == S_WALK && bus_ready) begin
        r_desc_base <= bus_data_rd[31:20];
        r_desc_dom  <= bus_data_rd[8:5];
        r_desc_ap   <= bus_data_rd[11:10];
      end
    end
  end

  // A flush coinciding with FILL wins, so the following lookup misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_rr    <= '0;
    end else if (tlb_flush) begin
      r_valid <= '0;
    end else if (r_state == S_FILL) begin
      r_valid[w_victim] <= 1'b1;
      if (w_all_valid) r_rr <= (r_rr == PTR_W'(TLB_ENTRIES - 1)) ? '0 : r_rr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FILL && !tlb_flush) begin
      r_tag[w_victim]  <= w_idx;
      r_base[w_victim] <= r_desc_base;
      r_dom[w_victim]  <= r_desc_dom;
      r_ap[w_victim]   <= r_desc_ap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready    <= 1'b0;
      r_req_fault    <= 1'b0;
      r_req_data_rd  <= '0;
      r_bus_start    <= 1'b0;
      r_bus_addr     <= '0;
      r_bus_write    <= 1'b0;
      r_bus_data_wr  <= '0;
      r_bus_be       <= '0;
      r_fault_addr   <= '0;
      r_fault_type   <= FT_TRANS;
      r_fault_domain <= '0;
    end else begin
      r_bus_start <= w_walk_go | w_acc_go;
      r_req_ready <= w_done | w_fault_go;
      r_req_fault <= w_fault_go;
      if (w_walk_go) begin
        r_bus_addr  <= {mmu_ttbr, w_idx};
        r_bus_write <= 1'b0;
        r_bus_be    <= 4'hF;
      end else if (w_acc_go) begin
        r_bus_addr    <= w_acc_addr;
        r_bus_write   <= w_acc_write;
        r_bus_data_wr <= w_acc_wd;
        r_bus_be      <= w_acc_be;
      end
      if (w_done) r_req_data_rd <= bus_data_rd;
      if (w_fault_go) begin
        r_fault_addr   <= r_va;
        r_fault_type   <= w_ftype;
        r_fault_domain <= w_fdom;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign req_fault    = r_req_fault;
  assign req_data_rd  = r_req_data_rd;
  assign bus_start    = r_bus_start;
  assign bus_addr     = r_bus_addr;
  assign bus_write    = r_bus_write;
  assign bus_data_wr  = r_bus_data_wr;
  assign bus_data_be  = r_bus_be;
  assign fault_addr   = r_fault_addr;
  assign fault_type   = r_fault_type;
  assign fault_domain = r_fault_domain;
endmodule
